// File: rtl/yuv_conv_arbiter.sv
// ---------------------------------------------------------------------------
// yuv_conv_arbiter
//
// Shares one YUV444-to-RGB converter pipeline between N_SRC video streams.
// Ingress: a packet-level round-robin arbiter passes the granted source's
// beats straight through to the converter input. Once a packet's last beat
// is accepted there is one dead (IDLE) cycle before the next packet starts.
// Egress: the converter does not carry a destination id. An order FIFO
// remembers the source id of each granted packet, and the head of that FIFO
// steers converted beats back to the matching sink.
//
// Ports
//   aclk, areset        clock, synchronous active-high reset
//   s_data/valid/last   per-source input streams (source i at slice i)
//   s_ready             per-source accept
//   cv_in_*             stream into the shared converter
//   cv_out_*            stream out of the shared converter
//   m_data/valid/last   per-sink output streams (data broadcast to all sinks)
//   m_ready             per-sink accept
//   inflight            packets granted but not yet fully delivered
// ---------------------------------------------------------------------------
module yuv_conv_arbiter #(
  parameter int N_SRC       = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                               aclk,
  input  logic                               areset,
  input  logic [N_SRC*DATA_WIDTH-1:0]        s_data,
  input  logic [N_SRC-1:0]                   s_valid,
  input  logic [N_SRC-1:0]                   s_last,
  output logic [N_SRC-1:0]                   s_ready,
  output logic [DATA_WIDTH-1:0]              cv_in_data,
  output logic                               cv_in_valid,
  output logic                               cv_in_last,
  input  logic                               cv_in_ready,
  input  logic [DATA_WIDTH-1:0]              cv_out_data,
  input  logic                               cv_out_valid,
  input  logic                               cv_out_last,
  output logic                               cv_out_ready,
  output logic [N_SRC*DATA_WIDTH-1:0]        m_data,
  output logic [N_SRC-1:0]                   m_valid,
  output logic [N_SRC-1:0]                   m_last,
  input  logic [N_SRC-1:0]                   m_ready,
  output logic [$clog2(ORDER_DEPTH+1)-1:0]   inflight
);

  localparam int SW = $clog2(N_SRC);
  localparam int PW = $clog2(ORDER_DEPTH);
  localparam int CW = $clog2(ORDER_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(ORDER_DEPTH);
  localparam logic [SW-1:0] LAST_SRC = SW'(N_SRC - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t          r_state;
  logic [SW-1:0]   r_grant;
  logic [SW-1:0]   r_lastGrant;

  logic [SW-1:0]   r_order [ORDER_DEPTH];
  logic [PW-1:0]   r_wrPtr;
  logic [PW-1:0]   r_rdPtr;
  logic [CW-1:0]   r_count;

  logic [DATA_WIDTH-1:0] w_srcData [N_SRC];
  logic            w_pickFound;
  logic [SW-1:0]   w_pick;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_inLastXfer;
  logic [SW-1:0]   w_head;

  // Source index k positions after base, wrapping modulo N_SRC.
  function automatic logic [SW-1:0] wrapIdx(input logic [SW-1:0] base, input int k);
    return SW'((int'(base) + k) % N_SRC);
  endfunction

  // Unpack the flat source bus so the grant can index it directly.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_unpack
    assign w_srcData[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: scan from the source after the last winner, with wrap,
  // so last_grant itself is considered only after everyone else.
  always_comb begin
    w_pickFound = 1'b0;
    w_pick      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      if (!w_pickFound && s_valid[wrapIdx(r_lastGrant, k)]) begin
        w_pickFound = 1'b1;
        w_pick      = wrapIdx(r_lastGrant, k);
      end
    end
  end

  // Full uses registered occupancy only, so a pop in the same cycle cannot
  // open room for a grant until the following cycle.
  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  assign w_push  = (r_state == ST_IDLE) && w_pickFound && !w_full;

  // Ingress pass-through: the granted source talks straight to the converter.
  always_comb begin
    s_ready     = '0;
    cv_in_data  = '0;
    cv_in_valid = 1'b0;
    cv_in_last  = 1'b0;
    if (r_state == ST_GRANT) begin
      cv_in_data       = w_srcData[r_grant];
      cv_in_valid      = s_valid[r_grant];
      cv_in_last       = s_last[r_grant];
      s_ready[r_grant] = cv_in_ready;
    end
  end

  assign w_inLastXfer = (r_state == ST_GRANT) && s_valid[r_grant] &&
                        cv_in_ready && s_last[r_grant];

  // Ingress FSM. The grant is held until the granted packet's last beat is
  // accepted, even if the source idles mid-packet, so packets never interleave.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_lastGrant <= LAST_SRC;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_push) begin
            r_grant <= w_pick;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_inLastXfer) begin
            r_lastGrant <= r_grant;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Order FIFO storage; entries beyond the pointers are never read.
  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_order[r_wrPtr] <= w_pick;
    end
  end

  // Order FIFO pointers and occupancy. Depth is a power of two so the
  // pointers wrap naturally.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_order[r_rdPtr];

  // Egress steering: only the sink at the FIFO head sees the converter, and
  // its ready is the converter's ready, preserving packet order.
  always_comb begin
    m_valid      = '0;
    m_last       = '0;
    cv_out_ready = 1'b0;
    if (!w_empty) begin
      m_valid[w_head] = cv_out_valid;
      m_last[w_head]  = cv_out_last;
      cv_out_ready    = m_ready[w_head];
    end
  end

  assign w_pop    = !w_empty && cv_out_valid && cv_out_ready && cv_out_last;
  assign m_data   = {N_SRC{cv_out_data}};
  assign inflight = r_count;

  // The converter can only emit data for packets we granted.
  a_noOrphanOutput : assert property (
    @(posedge aclk) disable iff (areset) !(cv_out_valid && w_empty)
  ) else $error("cv_out_valid asserted with no packet in flight");

  a_countBound : assert property (
    @(posedge aclk) disable iff (areset) (r_count <= DEPTH_C)
  ) else $error("order FIFO occupancy out of range");

endmodule

// File: tb/tb_yuv_conv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_yuv_conv_arbiter
//
// Directed bench for yuv_conv_arbiter (N_SRC=4, DATA_WIDTH=64, ORDER_DEPTH=4).
// The bench plays the sources, the sinks and an identity converter whose
// output can be held off or released one packet at a time. Beat data is
// tagged {src[7:0], 40'h0, pkt[7:0], beat[7:0]} so routing is visible.
// ---------------------------------------------------------------------------
module tb_yuv_conv_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int OD = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_ready;
  logic [DW-1:0]   cv_in_data;
  logic            cv_in_valid;
  logic            cv_in_last;
  logic            cv_in_ready;
  logic [DW-1:0]   cv_out_data;
  logic            cv_out_valid;
  logic            cv_out_last;
  logic            cv_out_ready;
  logic [N*DW-1:0] m_data;
  logic [N-1:0]    m_valid;
  logic [N-1:0]    m_last;
  logic [N-1:0]    m_ready;
  logic [2:0]      inflight;

  yuv_conv_arbiter #(
    .N_SRC       (N),
    .DATA_WIDTH  (DW),
    .ORDER_DEPTH (OD)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .cv_in_data   (cv_in_data),
    .cv_in_valid  (cv_in_valid),
    .cv_in_last   (cv_in_last),
    .cv_in_ready  (cv_in_ready),
    .cv_out_data  (cv_out_data),
    .cv_out_valid (cv_out_valid),
    .cv_out_last  (cv_out_last),
    .cv_out_ready (cv_out_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_last       (m_last),
    .m_ready      (m_ready),
    .inflight     (inflight)
  );

  always #5 aclk = ~aclk;

  // Bench-side stream state: bit 64 of a beat is its last flag.
  logic [64:0] srcQ    [N][$];
  logic [64:0] convQ   [$];
  logic [63:0] sinkLog [N][$];
  logic [63:0] cvInLog [$];
  int          grantLog[$];
  int          inCycles[$];

  logic [N-1:0] srcEn;
  logic [N-1:0] sinkReady;
  logic         cvInReady;
  int           cvOutBudget;
  int           cycle;
  bit           inPktStart;
  int           maxInflight;
  int           minInflight;

  logic [2:0]   smpInflight;
  logic [N-1:0] smpSReady;
  logic [N-1:0] smpMValid;
  logic         smpCvInValid;
  logic         smpCvOutReady;

  int vecCount;
  int missCount;

  function automatic logic [63:0] mkData(input int src, input int pkt, input int beat);
    return {8'(src), 40'h0, 8'(pkt), 8'(beat)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 'h%0h, expected 'h%0h", tag, observed, expected);
    end
  endtask

  task automatic addPacket(input int src, input int pkt, input int beats);
    for (int b = 0; b < beats; b++) begin
      srcQ[src].push_back({(b == beats - 1), mkData(src, pkt, b)});
    end
  endtask

  task automatic clearBench();
    for (int i = 0; i < N; i++) begin
      srcQ[i].delete();
      sinkLog[i].delete();
    end
    convQ.delete();
    cvInLog.delete();
    grantLog.delete();
    inCycles.delete();
    inPktStart  = 1'b1;
    maxInflight = 0;
    minInflight = 99;
  endtask

  function automatic logic [63:0] packGrants();
    logic [63:0] v;
    v = '0;
    foreach (grantLog[k]) v = (v << 4) | 64'(grantLog[k]);
    return v;
  endfunction

  function automatic logic [63:0] sinkAt(input int i, input int k);
    if (k < sinkLog[i].size()) return sinkLog[i][k];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [63:0] cvInAt(input int k);
    if (k < cvInLog.size()) return cvInLog[k];
    return 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic int totalSink();
    int t;
    t = 0;
    for (int i = 0; i < N; i++) t += sinkLog[i].size();
    return t;
  endfunction

  task automatic driveInputs();
    for (int i = 0; i < N; i++) begin
      if (srcQ[i].size() > 0) begin
        s_valid[i]            = srcEn[i];
        s_data[i*DW +: DW]    = srcQ[i][0][63:0];
        s_last[i]             = srcQ[i][0][64];
      end else begin
        s_valid[i]            = 1'b0;
        s_data[i*DW +: DW]    = '0;
        s_last[i]             = 1'b0;
      end
    end
    m_ready     = sinkReady;
    cv_in_ready = cvInReady;
    if (convQ.size() > 0 && cvOutBudget > 0) begin
      cv_out_valid = 1'b1;
      cv_out_data  = convQ[0][63:0];
      cv_out_last  = convQ[0][64];
    end else begin
      cv_out_valid = 1'b0;
      cv_out_data  = '0;
      cv_out_last  = 1'b0;
    end
  endtask

  // One clock: drive, sample mid-cycle, then retire the handshakes that
  // happened on the rising edge.
  task automatic applyStimulus();
    logic         inXfer;
    logic         outXfer;
    logic [64:0]  inBeat;
    logic [N-1:0] srcAcc;
    bit           found;
    driveInputs();
    @(negedge aclk);
    inXfer        = cv_in_valid && cv_in_ready;
    inBeat        = {cv_in_last, cv_in_data};
    srcAcc        = s_valid & s_ready;
    outXfer       = cv_out_valid && cv_out_ready;
    smpInflight   = inflight;
    smpSReady     = s_ready;
    smpMValid     = m_valid;
    smpCvInValid  = cv_in_valid;
    smpCvOutReady = cv_out_ready;
    if (int'(inflight) > maxInflight) maxInflight = int'(inflight);
    if (int'(inflight) < minInflight) minInflight = int'(inflight);
    if (inXfer) begin
      cvInLog.push_back(cv_in_data);
      inCycles.push_back(cycle);
      if (inPktStart) begin
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
          if (srcAcc[j] && !found) begin
            grantLog.push_back(j);
            found = 1'b1;
          end
        end
      end
      inPktStart = cv_in_last;
    end
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_ready[i]) sinkLog[i].push_back(m_data[i*DW +: DW]);
    end
    @(posedge aclk);
    #1;
    for (int j = 0; j < N; j++) begin
      if (srcAcc[j] && srcQ[j].size() > 0) void'(srcQ[j].pop_front());
    end
    if (inXfer) convQ.push_back(inBeat);
    if (outXfer && convQ.size() > 0) begin
      if (convQ[0][64] && cvOutBudget > 0) cvOutBudget--;
      void'(convQ.pop_front());
    end
    cycle++;
  endtask

  task automatic resetDut();
    areset      = 1'b1;
    srcEn       = '1;
    sinkReady   = '1;
    cvInReady   = 1'b1;
    cvOutBudget = 1000;
    clearBench();
    repeat (2) applyStimulus();
    areset = 1'b0;
  endtask

  initial begin
    int gap0, gap1, badTag, gapLen;
    vecCount    = 0;
    missCount   = 0;
    cycle       = 0;
    areset      = 1'b1;
    srcEn       = '1;
    sinkReady   = '1;
    cvInReady   = 1'b1;
    cvOutBudget = 1000;
    clearBench();
    driveInputs();

    // Reset state with a source waiting: first post-reset cycle is IDLE.
    resetDut();
    addPacket(1, 0, 1);
    applyStimulus();
    checkOutput("rst_inflight",  64'(smpInflight),   64'h0);
    checkOutput("rst_s_ready",   64'(smpSReady),     64'h0);
    checkOutput("rst_cv_in_vld", 64'(smpCvInValid),  64'h0);
    checkOutput("rst_m_valid",   64'(smpMValid),     64'h0);
    checkOutput("rst_cvo_ready", 64'(smpCvOutReady), 64'h0);

    // All four sources, 2-beat packets, source 0 has a second packet.
    resetDut();
    addPacket(0, 0, 2);
    addPacket(1, 0, 2);
    addPacket(2, 0, 2);
    addPacket(3, 0, 2);
    addPacket(0, 1, 2);
    for (int n = 0; n < 200 && totalSink() < 10; n++) applyStimulus();
    checkOutput("rr_grant_order", packGrants(), 64'h01230);
    checkOutput("rr_sink0_beats", 64'(sinkLog[0].size()), 64'd4);
    checkOutput("rr_sink1_beats", 64'(sinkLog[1].size()), 64'd2);
    checkOutput("rr_sink3_beats", 64'(sinkLog[3].size()), 64'd2);
    checkOutput("rr_sink2_word1", sinkAt(2, 1), 64'h0200_0000_0000_0001);
    checkOutput("rr_sink0_word2", sinkAt(0, 2), 64'h0000_0000_0000_0100);
    badTag = 0;
    for (int i = 0; i < N; i++) begin
      foreach (sinkLog[i][k]) if (sinkLog[i][k][63:56] != 8'(i)) badTag++;
    end
    checkOutput("rr_wrong_sink", 64'(badTag), 64'h0);

    // Single source, three 1-beat packets: one dead cycle between packets.
    resetDut();
    addPacket(2, 0, 1);
    addPacket(2, 1, 1);
    addPacket(2, 2, 1);
    for (int n = 0; n < 100 && sinkLog[2].size() < 3; n++) applyStimulus();
    gap0 = (inCycles.size() >= 3) ? inCycles[1] - inCycles[0] : -1;
    gap1 = (inCycles.size() >= 3) ? inCycles[2] - inCycles[1] : -1;
    checkOutput("one_grants",   packGrants(), 64'h222);
    checkOutput("one_gap0",     64'(gap0), 64'd2);
    checkOutput("one_gap1",     64'(gap1), 64'd2);
    checkOutput("one_max_infl", 64'(maxInflight), 64'd1);
    checkOutput("one_word2",    sinkAt(2, 2), 64'h0200_0000_0000_0200);

    // Converter output stalled: exactly ORDER_DEPTH grants until one drains.
    resetDut();
    cvOutBudget = 0;
    addPacket(0, 0, 1);
    addPacket(1, 0, 1);
    addPacket(2, 0, 1);
    addPacket(3, 0, 1);
    addPacket(0, 1, 1);
    repeat (30) applyStimulus();
    checkOutput("full_inflight", 64'(smpInflight), 64'd4);
    checkOutput("full_grants",   packGrants(), 64'h0123);
    cvOutBudget = 1;
    minInflight = 99;
    repeat (20) applyStimulus();
    checkOutput("full_min_infl",  64'(minInflight), 64'd3);
    checkOutput("full_grants5",   packGrants(), 64'h01230);
    checkOutput("full_inflight2", 64'(smpInflight), 64'd4);
    checkOutput("full_sink0",     64'(sinkLog[0].size()), 64'd1);

    // Head-of-line: sink 1 not ready blocks sink 3's packet behind it.
    resetDut();
    sinkReady = 4'b1101;
    addPacket(1, 0, 2);
    addPacket(3, 0, 2);
    repeat (30) applyStimulus();
    checkOutput("hol_sink1_none", 64'(sinkLog[1].size()), 64'd0);
    checkOutput("hol_sink3_none", 64'(sinkLog[3].size()), 64'd0);
    checkOutput("hol_cvo_ready",  64'(smpCvOutReady), 64'h0);
    checkOutput("hol_m_valid",    64'(smpMValid), 64'b0010);
    checkOutput("hol_inflight",   64'(smpInflight), 64'd2);
    sinkReady = '1;
    repeat (30) applyStimulus();
    checkOutput("hol_sink1_done", 64'(sinkLog[1].size()), 64'd2);
    checkOutput("hol_sink3_done", 64'(sinkLog[3].size()), 64'd2);
    checkOutput("hol_sink3_w0",   sinkAt(3, 0), 64'h0300_0000_0000_0000);
    checkOutput("hol_inflight0",  64'(smpInflight), 64'd0);

    // Source 0 idles mid-packet while source 1 waits: grant stays on 0.
    resetDut();
    addPacket(0, 0, 3);
    addPacket(1, 0, 1);
    for (int n = 0; n < 20 && cvInLog.size() < 1; n++) applyStimulus();
    srcEn[0] = 1'b0;
    repeat (3) applyStimulus();
    gapLen = cvInLog.size();
    srcEn[0] = 1'b1;
    for (int n = 0; n < 30 && cvInLog.size() < 4; n++) applyStimulus();
    checkOutput("hold_gap_beats", 64'(gapLen), 64'd1);
    checkOutput("hold_beat1",     cvInAt(1), 64'h0000_0000_0000_0001);
    checkOutput("hold_beat2",     cvInAt(2), 64'h0000_0000_0000_0002);
    checkOutput("hold_beat3",     cvInAt(3), 64'h0100_0000_0000_0000);
    checkOutput("hold_grants",    packGrants(), 64'h01);

    // Reset while granted with two packets in flight.
    resetDut();
    cvOutBudget = 0;
    addPacket(1, 0, 1);
    addPacket(2, 0, 4);
    for (int n = 0; n < 20 && !(smpInflight == 3'd2 && cvInLog.size() >= 2); n++)
      applyStimulus();
    checkOutput("mid_inflight", 64'(smpInflight), 64'd2);
    checkOutput("mid_s_ready",  64'(smpSReady), 64'b0100);
    areset = 1'b1;
    clearBench();
    applyStimulus();
    areset = 1'b0;
    addPacket(0, 0, 1);
    addPacket(2, 1, 1);
    cvOutBudget = 1000;
    applyStimulus();
    checkOutput("mrst_inflight", 64'(smpInflight),   64'h0);
    checkOutput("mrst_s_ready",  64'(smpSReady),     64'h0);
    checkOutput("mrst_cv_in",    64'(smpCvInValid),  64'h0);
    checkOutput("mrst_m_valid",  64'(smpMValid),     64'h0);
    checkOutput("mrst_cvo_rdy",  64'(smpCvOutReady), 64'h0);
    for (int n = 0; n < 30 && grantLog.size() < 2; n++) applyStimulus();
    checkOutput("mrst_grants",   packGrants(), 64'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
